cdma_lite_responder: RTL
========================

// Module: cdma_lite_responder
// PURPOSE
//  AXI4-Lite slave that answers the CDMA init master: decodes CR/SR/SA/DA/BTT writes/reads.
//  Models a transfer as a timed busy period started by a BTT write; raises IOC on completion.
//  Sits on the master's M00_AXI port in the bfm_design so init sequences can be checked without the Xilinx CDMA.
// PARAMETERS
//  ADDR_W    6   AXI-Lite address width (byte address; bits [1:0] ignored)
//  BTT_W     23  implemented width of BTT register (bytes-to-transfer)
//  XFER_LAT  4   fixed extra busy cycles added to each transfer
// PORTS
//  ACLK          in   1       clock, all logic on rising edge
//  ARESET        in   1       synchronous, active-high reset
//  S_AXI_AWADDR  in   ADDR_W  write address;  S_AXI_AWPROT in 3 (ignored)
//  S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1   write-address handshake
//  S_AXI_WDATA   in   32      write data;  S_AXI_WSTRB in 4 byte enables
//  S_AXI_WVALID  in 1 / S_AXI_WREADY out 1    write-data handshake
//  S_AXI_BRESP   out  2       write response;  S_AXI_BVALID out 1 / S_AXI_BREADY in 1
//  S_AXI_ARADDR  in   ADDR_W  read address;  S_AXI_ARPROT in 3 (ignored)
//  S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1   read-address handshake
//  S_AXI_RDATA   out  32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1
//  IRQ           out  1       SR.IOC_Irq & CR.IOC_IrqEn (registered)
//  XFER_BUSY     out  1       high while modelled transfer in progress (= ~SR.Idle)
// BEHAVIOUR
//  Reset: all READY/VALID 0 on reset cycle, then AWREADY=WREADY=ARREADY=1; BRESP=RRESP=0, RDATA=0, IRQ=0, XFER_BUSY=0.
//  Map: 0x00 CR {bit12 IOC_IrqEn RW, bit2 Reset self-clear}; 0x04 SR {bit12 IOC_Irq W1C, bit1 Idle RO};
//   0x18 SA RW32; 0x20 DA RW32; 0x28 BTT RW[BTT_W-1:0]. Unlisted bits read 0. Reset: all 0 except SR.Idle=1.
//  Write: AW and W accepted independently into one-entry holds; AWREADY=~aw_held&~BVALID, WREADY=~w_held&~BVALID.
//   Both held & ~BVALID -> register update that cycle, BVALID=1 next cycle, holds cleared; BVALID held until BREADY.
//   WSTRB applied per byte for RW bits and for W1C. AW/W in same cycle -> BVALID two cycles after handshake.
//  Read: ARREADY=~RVALID; accept -> RVALID+RDATA next cycle, held stable until RREADY. Read has no side effects.
//  Transfer: BTT write (any strobe) while Idle=1 and written BTT!=0 -> Idle=0, timer loads ((BTT+3)>>2)+XFER_LAT,
//   decrements each cycle; at 0 -> Idle=1, IOC_Irq=1. BTT=0 write: register updated, no transfer, no IOC.
//   BTT write while Idle=0: register unchanged, response OKAY, running transfer unaffected.
//  Collisions: W1C of IOC_Irq in same cycle as completion -> IOC_Irq stays 1 (set wins).
//  CR.Reset=1 write: next cycle CR/SA/DA/BTT=0, IOC_Irq=0, Idle=1, timer aborted (no IOC); B response still issued;
//   in-flight read completes normally. ARESET mid-transaction drops BVALID/RVALID with no response.
//  IRQ updates cycle after IOC_Irq/IOC_IrqEn change.
// CONFIGURATION
//  CDMA_RESP_SLVERR_EN defined: unmapped address -> write ignored, BRESP=2'b10; read RDATA=0, RRESP=2'b10.
//  Not defined: unmapped address -> write ignored, BRESP=OKAY; read RDATA=0, RRESP=OKAY. Mapped always OKAY.
// STRUCTURE
//  Package cdma_lite_pkg: register offsets (CR/SR/SA/DA/BTT), bit indices (IOC_IRQEN=12, RESET=2, IDLE=1,
//   IOC_IRQ=12), resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
//  Sub-module cdma_xfer_timer: load/count/abort inputs, busy and one-cycle done outputs; width BTT_W.
// TESTING
//  1 Reset: ARESET 3 cycles -> SR reads 0x00000002, IRQ=0, AWREADY=WREADY=ARREADY=1.
//  2 W before AW (2 cycles apart) to SA 0x18 = 0xA5A5_0000, BREADY=0 for 5 cycles -> BVALID held, READYs low;
//    readback 0xA5A50000; WSTRB=4'b0011 write 0x1234 -> 0xA5A51234.
//  3 CR=0x1000, BTT=64 -> XFER_BUSY=1 exactly 16+4=20 cycles, then SR=0x1002, IRQ=1;
//    write SR=0x1000 -> SR=0x0002, IRQ=0 next cycle.
//  4 BTT=100 write while busy -> BTT readback unchanged, busy length unchanged; W1C on completion cycle -> IOC=1.
//  5 Mid-transfer CR=0x0004 -> SA/DA/BTT read 0, SR=0x0002, no IRQ, BVALID/BRESP=OKAY.
//  6 Access 0x3C: with CDMA_RESP_SLVERR_EN BRESP/RRESP=2'b10, without =2'b00; RDATA=0 both; RREADY stall holds RDATA.

Source files
------------

// File: rtl/cdma_lite_pkg.sv
// Shared register map, bit positions, response codes and decode helpers for the
// CDMA-lite responder.
package cdma_lite_pkg;

  localparam logic [7:0] OFF_CR  = 8'h00;
  localparam logic [7:0] OFF_SR  = 8'h04;
  localparam logic [7:0] OFF_SA  = 8'h18;
  localparam logic [7:0] OFF_DA  = 8'h20;
  localparam logic [7:0] OFF_BTT = 8'h28;

  localparam int IOC_IRQEN_BIT = 12;
  localparam int RESET_BIT     = 2;
  localparam int IDLE_BIT      = 1;
  localparam int IOC_IRQ_BIT   = 12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_CR,
    SEL_SR,
    SEL_SA,
    SEL_DA,
    SEL_BTT,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [7:0] byte_addr);
    case (byte_addr & 8'hFC)
      OFF_CR:  return SEL_CR;
      OFF_SR:  return SEL_SR;
      OFF_SA:  return SEL_SA;
      OFF_DA:  return SEL_DA;
      OFF_BTT: return SEL_BTT;
      default: return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cdma_lite_responder_if.sv
// AXI4-Lite bus bundle between the CDMA init master and the responder.
interface cdma_lite_responder_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  // Every channel: a transfer happens on a rising edge where VALID and READY are
  // both high; VALID and its payload stay stable until that edge.
  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/cdma_xfer_timer.sv
// Busy-period model of one DMA transfer: ceil(BTT/4) word beats plus a fixed
// latency, with a one-cycle done pulse on the final busy cycle.
module cdma_xfer_timer #(
  parameter int BTT_W    = 23,
  parameter int XFER_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [BTT_W-1:0] btt_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o
);
  logic [BTT_W-1:0] cnt_q, cnt_d;
  logic [BTT_W:0]   btt_round;

  assign btt_round = {1'b0, btt_i} + (BTT_W+1)'(3);

  always_comb begin
    cnt_d = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = BTT_W'(btt_round >> 2) + BTT_W'(XFER_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - BTT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == BTT_W'(1));
endmodule

// File: rtl/cdma_lite_responder.sv
// AXI4-Lite register responder standing in for the Xilinx CDMA during init checks.
// Define CDMA_RESP_SLVERR_EN to answer unmapped addresses with SLVERR instead of OKAY.
module cdma_lite_responder
  import cdma_lite_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int BTT_W    = 23,
  parameter int XFER_LAT = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  cdma_lite_responder_if.slave s_axi,
  output logic                 IRQ,
  output logic                 XFER_BUSY
);
`ifdef CDMA_RESP_SLVERR_EN
  localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

  logic              aw_held_q, w_held_q, bvalid_q, rvalid_q, irq_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        bresp_q, rresp_q;
  logic              ioc_en_q, ioc_en_d, ioc_irq_q, ioc_irq_d;
  logic [31:0]       sa_q, sa_d, da_q, da_d;
  logic [BTT_W-1:0]  btt_q, btt_d, btt_new;
  logic [1:0]        bresp_d, rd_resp;
  logic [31:0]       rd_data;
  logic              aw_hs, w_hs, ar_hs, do_write, soft_rst, xfer_load;
  logic              xfer_busy, xfer_done;
  reg_sel_e          wr_sel, rd_sel;
  logic              unused_prot;

  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign s_axi.S_AXI_AWREADY = ~ARESET & ~aw_held_q & ~bvalid_q;
  assign s_axi.S_AXI_WREADY  = ~ARESET & ~w_held_q & ~bvalid_q;
  assign s_axi.S_AXI_ARREADY = ~ARESET & ~rvalid_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign IRQ                 = irq_q;
  assign XFER_BUSY           = xfer_busy;

  assign aw_hs    = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs     = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
  assign ar_hs    = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign do_write = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_sel   = decode_reg(8'(awaddr_q));
  assign rd_sel   = decode_reg(8'(s_axi.S_AXI_ARADDR));
  assign btt_new  = BTT_W'(merge_strb(32'(btt_q), wdata_q, wstrb_q));

  always_comb begin
    ioc_en_d  = ioc_en_q;
    ioc_irq_d = ioc_irq_q;
    sa_d      = sa_q;
    da_d      = da_q;
    btt_d     = btt_q;
    bresp_d   = bresp_q;
    soft_rst  = 1'b0;
    xfer_load = 1'b0;
    if (do_write) begin
      bresp_d = RESP_OKAY;
      case (wr_sel)
        SEL_CR: begin
          if (wstrb_q[RESET_BIT/8] && wdata_q[RESET_BIT]) soft_rst = 1'b1;
          if (wstrb_q[IOC_IRQEN_BIT/8]) ioc_en_d = wdata_q[IOC_IRQEN_BIT];
        end
        SEL_SR: if (wstrb_q[IOC_IRQ_BIT/8] && wdata_q[IOC_IRQ_BIT]) ioc_irq_d = 1'b0;
        SEL_SA: sa_d = merge_strb(sa_q, wdata_q, wstrb_q);
        SEL_DA: da_d = merge_strb(da_q, wdata_q, wstrb_q);
        SEL_BTT: begin
          // BTT is frozen while a transfer runs; the write is still acknowledged.
          if (!xfer_busy) begin
            btt_d     = btt_new;
            xfer_load = (btt_new != '0);
          end
        end
        default: bresp_d = UNMAPPED_RESP;
      endcase
    end
    // Completion beats a same-cycle W1C; a soft reset beats everything.
    if (xfer_done) ioc_irq_d = 1'b1;
    if (soft_rst) begin
      ioc_en_d  = 1'b0;
      ioc_irq_d = 1'b0;
      sa_d      = '0;
      da_d      = '0;
      btt_d     = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_CR:  rd_data[IOC_IRQEN_BIT] = ioc_en_q;
      SEL_SR: begin
        rd_data[IOC_IRQ_BIT] = ioc_irq_q;
        rd_data[IDLE_BIT]    = ~xfer_busy;
      end
      SEL_SA:  rd_data = sa_q;
      SEL_DA:  rd_data = da_q;
      SEL_BTT: rd_data = 32'(btt_q);
      default: rd_resp = UNMAPPED_RESP;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ioc_en_q  <= 1'b0;
      ioc_irq_q <= 1'b0;
      sa_q      <= '0;
      da_q      <= '0;
      btt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axi.S_AXI_AWADDR;
      end else if (do_write) begin
        aw_held_q <= 1'b0;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi.S_AXI_WDATA;
        wstrb_q  <= s_axi.S_AXI_WSTRB;
      end else if (do_write) begin
        w_held_q <= 1'b0;
      end
      if (do_write)                bvalid_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
      bresp_q <= bresp_d;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      ioc_en_q  <= ioc_en_d;
      ioc_irq_q <= ioc_irq_d;
      sa_q      <= sa_d;
      da_q      <= da_d;
      btt_q     <= btt_d;
      irq_q     <= ioc_irq_q & ioc_en_q;
    end
  end

  cdma_xfer_timer #(
    .BTT_W    (BTT_W),
    .XFER_LAT (XFER_LAT)
  ) u_timer (
    .clk     (ACLK),
    .rst     (ARESET),
    .load_i  (xfer_load),
    .btt_i   (btt_new),
    .abort_i (soft_rst),
    .busy_o  (xfer_busy),
    .done_o  (xfer_done)
  );
endmodule
